// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / load unit) writeback arbiter driving a register-file write port,
// with a per-register pending scoreboard. Define REGFILE_WB_ROUND_ROBIN_EN for round-robin arbitration.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    output logic            alu_ready,

    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_val,
    output logic            mem_ready,

    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,

    output logic [4:0]      rd,
    output logic [XLEN-1:0] valR,
    output logic            write_en,

    output logic [31:0]     pending
);

    logic            w_grant_alu;
    logic            w_grant_mem;
    logic            w_xfer;
    logic [4:0]      w_xfer_rd;
    logic [XLEN-1:0] w_xfer_val;
    logic [31:0]     w_pending_nxt;

    logic            r_write_en;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_val;
    logic [31:0]     r_pending;

`ifdef REGFILE_WB_ROUND_ROBIN_EN
    // r_last_mem = 0 means the ALU was granted last, so mem wins the next contention.
    logic r_last_mem;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (reset_n) begin
            if (alu_valid && mem_valid) begin
                if (r_last_mem) begin
                    w_grant_alu = 1'b1;
                end else begin
                    w_grant_mem = 1'b1;
                end
            end else begin
                w_grant_alu = alu_valid;
                w_grant_mem = mem_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last_mem <= 1'b0;
        end else if (w_grant_mem) begin
            r_last_mem <= 1'b1;
        end else if (w_grant_alu) begin
            r_last_mem <= 1'b0;
        end
    end
`else
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        if (reset_n) begin
            w_grant_mem = mem_valid;
            w_grant_alu = alu_valid && !mem_valid;
        end
    end
`endif

    assign alu_ready  = w_grant_alu;
    assign mem_ready  = w_grant_mem;
    assign w_xfer     = w_grant_alu || w_grant_mem;
    assign w_xfer_rd  = w_grant_mem ? mem_rd  : alu_rd;
    assign w_xfer_val = w_grant_mem ? mem_val : alu_val;

    // Write-port registers; rd/valR only move when a real (non-x0) write is launched.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_write_en <= 1'b0;
            r_rd       <= 5'd0;
            r_val      <= '0;
        end else begin
            r_write_en <= w_xfer && (w_xfer_rd != 5'd0);
            if (w_xfer && (w_xfer_rd != 5'd0)) begin
                r_rd  <= w_xfer_rd;
                r_val <= w_xfer_val;
            end
        end
    end

    // Clear on commit first, then set on issue, so a same-edge new claim survives.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_write_en) begin
            w_pending_nxt[r_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign write_en = r_write_en;
    assign rd       = r_rd;
    assign valR     = r_val;
    assign pending  = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter; expectations follow REGFILE_WB_ROUND_ROBIN_EN when defined.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_val;
    logic            alu_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_val;
    logic            mem_ready;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] valR;
    logic            write_en;
    logic [31:0]     pending;

    int n_checks = 0;
    int n_err    = 0;

    regfile_wb_arbiter #(.XLEN(XLEN)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_val     (alu_val),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_val     (mem_val),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rd          (rd),
        .valR        (valR),
        .write_en    (write_en),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp_mem [4];
        logic [4:0] last_rd;
        logic [31:0] last_val;
`ifdef REGFILE_WB_ROUND_ROBIN_EN
        exp_mem = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        reset_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_val = '0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_val = '0;
        issue_valid = 1'b0; issue_rd = 5'd0;

        // Reset state
        tick();
        tick();
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_valR", valR, 32'd0);
        check("rst_pending", pending, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd2;
        #1;
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        alu_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Single ALU writeback
        alu_valid = 1'b1; alu_rd = 5'd5; alu_val = 32'hDEADBEEF;
        #1;
        check("alu_ready", 32'(alu_ready), 32'd1);
        check("alu_only_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        check("alu_we", 32'(write_en), 32'd1);
        check("alu_rd", 32'(rd), 32'd5);
        check("alu_valR", valR, 32'hDEADBEEF);
        check("alu_pending_nochange", pending, 32'd0);
        tick();
        check("idle_we", 32'(write_en), 32'd0);
        check("idle_rd_hold", 32'(rd), 32'd5);
        check("idle_valR_hold", valR, 32'hDEADBEEF);

        // Contention for 4 cycles
        alu_valid = 1'b1; alu_rd = 5'd3; alu_val = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_val = 32'h77;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont%0d_mem_ready", i), 32'(mem_ready), 32'(exp_mem[i]));
            check($sformatf("cont%0d_alu_ready", i), 32'(alu_ready), 32'(!exp_mem[i]));
            tick();
            check($sformatf("cont%0d_rd", i), 32'(rd), exp_mem[i] ? 32'd7 : 32'd3);
            check($sformatf("cont%0d_valR", i), valR, exp_mem[i] ? 32'h77 : 32'h33);
            check($sformatf("cont%0d_we", i), 32'(write_en), 32'd1);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        last_rd  = exp_mem[3] ? 5'd7 : 5'd3;
        last_val = exp_mem[3] ? 32'h77 : 32'h33;

        // Load writeback to x0 is accepted but suppressed
        mem_valid = 1'b1; mem_rd = 5'd0; mem_val = 32'h1234;
        #1;
        check("x0_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        check("x0_we", 32'(write_en), 32'd0);
        check("x0_rd_hold", 32'(rd), 32'(last_rd));
        check("x0_valR_hold", valR, last_val);
        check("x0_pending", pending, 32'd0);

        // Issue rd9 at E0, ALU transfer at E1, commit at E2
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        check("e0_pending9", pending, 32'h0000_0200);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_val = 32'h99;
        #1;
        check("e1_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("e1_pending9", pending, 32'h0000_0200);
        check("e1_we", 32'(write_en), 32'd1);
        tick();
        check("e2_pending9", pending, 32'd0);

        // Same-edge set and clear of rd4: set wins
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_val = 32'h44;
        tick();
        alu_valid = 1'b0;
        check("coll_we", 32'(write_en), 32'd1);
        check("coll_rd", 32'(rd), 32'd4);
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        check("coll_pending4", pending, 32'h0000_0010);

        // Claim of x0 never sets bit 0
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        check("x0_claim_pending", pending, 32'h0000_0010);

        // Reset in the cycle after an ALU transfer to rd6
        alu_valid = 1'b1; alu_rd = 5'd6; alu_val = 32'h66;
        tick();
        check("pre_rst_we", 32'(write_en), 32'd1);
        reset_n = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7;
        #1;
        check("rst2_alu_ready", 32'(alu_ready), 32'd0);
        check("rst2_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        check("rst2_we", 32'(write_en), 32'd0);
        check("rst2_pending", pending, 32'd0);
        check("rst2_rd", 32'(rd), 32'd0);
        check("rst2_valR", valR, 32'd0);

        // Leave last grant on mem, reset, then contention must go to mem again
        reset_n = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_val = 32'h88;
        tick();
        mem_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3;
        mem_valid = 1'b1; mem_rd = 5'd7;
        #1;
        check("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        check("post_rst_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("post_rst_rd", 32'(rd), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the register data width.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports alu_valid (input, 1), alu_rd (input, 5), alu_val (input, XLEN), alu_ready (output, 1): the ALU writeback requester.
REQ-005 SHALL have ports mem_valid (input, 1), mem_rd (input, 5), mem_val (input, XLEN), mem_ready (output, 1): the load-unit writeback requester.
REQ-006 SHALL have ports issue_valid (input, 1), issue_rd (input, 5): the destination register claimed by an issuing instruction.
REQ-007 SHALL have ports rd (output, 5), valR (output, XLEN), write_en (output, 1): drive the register-file write port.
REQ-008 SHALL have port pending (output, 32): one bit per register, set while a write to it is outstanding.

Function
REQ-009 SHALL complete a requester transfer in any cycle where its valid and ready are both 1.
REQ-010 SHALL grant at most one requester per cycle; ready SHALL be combinational from valid and the arbitration state; a non-granted valid requester SHALL see ready=0 and hold its inputs.
REQ-011 SHALL set the granted requester's ready even when its rd is 0.
REQ-012 SHALL keep write_en, rd and valR as registers: a transfer at edge E drives write_en=1, rd and valR with the granted values for the cycle after E (1-cycle latency).
REQ-013 SHALL drive write_en=0 in the following cycle when the transfer has rd=0 (x0 writes suppressed) or when no transfer occurs; rd/valR SHALL hold their last values when write_en=0.
REQ-014 SHALL sustain one transfer per cycle with no bubble between back-to-back transfers.
REQ-015 SHALL set pending[issue_rd] at the edge where issue_valid=1 and issue_rd!=0.
REQ-016 SHALL clear pending[rd] at the edge where write_en=1, which is the edge where the register file commits the write.
REQ-017 SHALL keep the bit set when set and clear target the same register at the same edge (the new claim wins).
REQ-018 SHALL hold pending[0] at 0 permanently.
REQ-019 SHALL ignore a transfer to a register whose pending bit is 0 for scoreboard purposes only: the write still occurs and no bit changes.

Reset
REQ-020 SHALL, while reset_n=0 at an edge, set write_en=0, rd=0, valR=0, pending=0 and restore the arbitration state to its reset value.
REQ-021 SHALL drive alu_ready=0 and mem_ready=0 combinationally while reset_n=0, so no transfer completes in a reset cycle.
REQ-022 SHALL discard a write registered in the cycle before reset asserts: write_en is 0 from the first post-reset-edge cycle.

Configuration
REQ-023 SHALL, with macro REGFILE_WB_ROUND_ROBIN_EN defined, arbitrate round-robin: a last-grant bit (reset value "ALU last") gives the other requester priority when both are valid; the bit updates only on a transfer.
REQ-024 SHALL, without REGFILE_WB_ROUND_ROBIN_EN, use fixed priority, mem over alu; no last-grant state SHALL exist.

Verification
REQ-025 Bench SHALL cover: reset, then alu_valid=1, alu_rd=5, alu_val=0xDEADBEEF -> alu_ready=1 that cycle; next cycle write_en=1, rd=5, valR=0xDEADBEEF.
REQ-026 Bench SHALL cover: alu and mem both valid for 4 cycles (rd 3 and 7) -> round-robin build grants mem, alu, mem, alu; fixed-priority build grants mem every cycle with alu_ready=0.
REQ-027 Bench SHALL cover: mem_valid=1, mem_rd=0, mem_val=0x1234 -> mem_ready=1, next cycle write_en=0, pending unchanged.
REQ-028 Bench SHALL cover: issue rd=9 at edge E0, alu transfer rd=9 at E1 -> pending[9]=1 after E0 and after E1; pending[9]=0 after E2.
REQ-029 Bench SHALL cover: issue_rd=4 while write_en=1 with rd=4 -> pending[4] stays 1.
REQ-030 Bench SHALL cover: reset_n=0 in the cycle after an alu transfer to rd=6 -> after the reset edge write_en=0, pending=0, both ready=0 during reset.
